// File: rtl/local_traffic_ni.sv
// ---------------------------------------------------------------------------
// local_traffic_ni
// Local-port network interface and traffic endpoint for one router tile.
//
// Injection side: a 16-bit LFSR decides when to create a flit
// {hdr=01, seq, addr}. The flit is then serialised onto inj_serial as
// one start bit followed by FW data bits, LSB first.
// Ejection side: deserialises frames arriving on ej_serial, keeps the last
// flit and counts received flits and flits whose address is not NODE_ID.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   enable       1 = injection allowed (ejection always runs)
//   rate         injection threshold: inject when lfsr[7:0] < rate
//   inj_serial   serial line into router local RX
//   inj_busy     router local RX busy; only holds back a new frame start
//   ej_serial    serial line from router local TX
//   ej_busy      high while a frame is being shifted in
//   sent_count   flits fully transmitted (wraps)
//   recv_count   flits fully received (wraps)
//   err_count    received flits with addr != NODE_ID (wraps)
//   last_rx_flit last received flit {hdr, payload, addr}
// ---------------------------------------------------------------------------
module local_traffic_ni #(
   parameter int unsigned NODE_ID = 0,
   parameter int unsigned ADDR_SZ = 4,
   parameter int unsigned PL_SZ   = 8,
   parameter int unsigned HDR_SZ  = 2,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [7:0]                        rate,
   output logic                              inj_serial,
   input  logic                              inj_busy,
   input  logic                              ej_serial,
   output logic                              ej_busy,
   output logic [15:0]                       sent_count,
   output logic [15:0]                       recv_count,
   output logic [15:0]                       err_count,
   output logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   last_rx_flit
);

   localparam int unsigned FW    = HDR_SZ + PL_SZ + ADDR_SZ;
   localparam int unsigned IDX_W = $clog2(FW);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FW - 1);

   typedef enum logic [2:0] {
      INJ_IDLE,
      INJ_PEND,
      INJ_START,
      INJ_DATA,
      INJ_GAP
   } inj_state_t;

   typedef enum logic {
      EJ_IDLE,
      EJ_DATA
   } ej_state_t;

   // ------------------------------------------------------------------
   // LFSR: Fibonacci, taps 16,14,13,11, shifting towards the MSB
   // ------------------------------------------------------------------
   logic [15:0] lfsr;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // NOTE: every clocked register in this file uses non-blocking (<=)
   // assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) lfsr <= SEED;
      else       lfsr <= {lfsr[14:0], lfsr_fb};
   end

   // ------------------------------------------------------------------
   // Injection FSM
   // ------------------------------------------------------------------
   inj_state_t          inj_state, inj_next;
   logic [FW-1:0]       inj_flit;
   logic [IDX_W-1:0]    inj_idx;
   logic [PL_SZ-1:0]    seq;
   logic                inj_latch;
   logic                inj_done;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      inj_next   = inj_state;
      inj_serial = 1'b0;
      inj_latch  = 1'b0;
      inj_done   = 1'b0;
      unique case (inj_state)
         INJ_IDLE: begin
            if (enable && (lfsr[7:0] < rate)) begin
               inj_latch = 1'b1;
               inj_next  = INJ_PEND;
            end
         end
         // A latched flit is always sent; only the router's busy delays it.
         INJ_PEND: begin
            if (!inj_busy) inj_next = INJ_START;
         end
         INJ_START: begin
            inj_serial = 1'b1;
            inj_next   = INJ_DATA;
         end
         INJ_DATA: begin
            inj_serial = inj_flit[inj_idx];
            if (inj_idx == LAST_IDX) begin
               inj_done = 1'b1;
               inj_next = INJ_GAP;
            end
         end
         INJ_GAP: begin
            inj_next = INJ_IDLE;
         end
         default: inj_next = INJ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inj_state  <= INJ_IDLE;
         inj_flit   <= '0;
         inj_idx    <= '0;
         seq        <= '0;
         sent_count <= '0;
      end else begin
         inj_state <= inj_next;
         if (inj_latch)
            inj_flit <= {HDR_SZ'(1), seq, lfsr[8+ADDR_SZ-1:8]};
         if (inj_state == INJ_START)
            inj_idx <= '0;
         else if (inj_state == INJ_DATA)
            inj_idx <= inj_idx + 1'b1;
         if (inj_done) begin
            sent_count <= sent_count + 16'd1;
            seq        <= seq + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Ejection FSM
   // ------------------------------------------------------------------
   ej_state_t           ej_state, ej_next;
   logic [IDX_W-1:0]    ej_idx;
   // Holds the first FW-1 bits; the final bit is taken straight off the line.
   logic [FW-2:0]       ej_shift;
   logic [FW-1:0]       ej_flit;
   logic                ej_done;

   assign ej_flit = {ej_serial, ej_shift};
   assign ej_busy = (ej_state == EJ_DATA);

   always_comb begin
      ej_next = ej_state;
      ej_done = 1'b0;
      unique case (ej_state)
         EJ_IDLE: begin
            if (ej_serial) ej_next = EJ_DATA;
         end
         EJ_DATA: begin
            if (ej_idx == LAST_IDX) begin
               ej_done = 1'b1;
               ej_next = EJ_IDLE;
            end
         end
         default: ej_next = EJ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ej_state     <= EJ_IDLE;
         ej_idx       <= '0;
         ej_shift     <= '0;
         last_rx_flit <= '0;
         recv_count   <= '0;
         err_count    <= '0;
      end else begin
         ej_state <= ej_next;
         if (ej_state == EJ_IDLE) begin
            ej_idx <= '0;
         end else begin
            ej_idx   <= ej_idx + 1'b1;
            ej_shift <= {ej_serial, ej_shift[FW-2:1]};
         end
         if (ej_done) begin
            last_rx_flit <= ej_flit;
            recv_count   <= recv_count + 16'd1;
            if (ej_flit[ADDR_SZ-1:0] != ADDR_SZ'(NODE_ID))
               err_count <= err_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_local_traffic_ni.sv
// ---------------------------------------------------------------------------
// tb_local_traffic_ni
// Scoreboard bench for local_traffic_ni. A reference model predicts each
// injected flit at the cycle it should be latched and pushes it into a queue.
// A monitor decodes frames on inj_serial and checks them against that queue.
// Received frames, whether looped back from the injector or driven by the
// bench, are checked when ej_busy falls.
// ---------------------------------------------------------------------------
module tb_local_traffic_ni;

   localparam int unsigned NODE_ID = 5;
   localparam int unsigned ADDR_SZ = 4;
   localparam int unsigned PL_SZ   = 8;
   localparam int unsigned HDR_SZ  = 2;
   localparam int unsigned FW      = HDR_SZ + PL_SZ + ADDR_SZ;
   localparam logic [15:0] SEED    = 16'hACE1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [7:0]    rate = 8'd0;
   logic          inj_busy = 1'b0;
   logic          ej_drv = 1'b0;
   logic          loop = 1'b0;
   logic          ej_line;
   logic          inj_serial;
   logic          ej_busy;
   logic [15:0]   sent_count, recv_count, err_count;
   logic [FW-1:0] last_rx_flit;

   assign ej_line = loop ? inj_serial : ej_drv;

   local_traffic_ni #(
      .NODE_ID(NODE_ID), .ADDR_SZ(ADDR_SZ), .PL_SZ(PL_SZ),
      .HDR_SZ(HDR_SZ), .SEED(SEED)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .rate(rate),
      .inj_serial(inj_serial), .inj_busy(inj_busy),
      .ej_serial(ej_line), .ej_busy(ej_busy),
      .sent_count(sent_count), .recv_count(recv_count),
      .err_count(err_count), .last_rx_flit(last_rx_flit)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // ------------------------------------------------------------------
   // Reference model and monitors (one process, evaluated mid-cycle)
   // ------------------------------------------------------------------
   longint        cyc = 0;
   logic [15:0]   m_lfsr;
   bit            m_valid = 0;
   logic [FW-1:0] inj_q[$];
   longint        inj_q_cyc[$];
   logic [PL_SZ-1:0] m_seq;
   bit            m_pending;
   longint        idle_at;
   bit            in_frame;
   int            bit_n;
   logic [FW-1:0] dec, cur_exp;
   longint        last_start = -1000;
   bit            chk_sent;
   logic [15:0]   m_sent, m_recv, m_err;
   bit            busy_prev, busy_prev2;
   logic [FW-1:0] ej_q[$];
   bit            busy_d;
   int            busy_len;
   bit            chk_rst;

   initial forever begin
      @(negedge clk);
      if (reset) begin
         m_valid   = 1;
         inj_q.delete();
         inj_q_cyc.delete();
         ej_q.delete();
         m_seq     = '0;
         m_pending = 0;
         idle_at   = cyc + 1;
         in_frame  = 0;
         chk_sent  = 0;
         last_start = -1000;
         m_sent = '0; m_recv = '0; m_err = '0;
         busy_d = 0; busy_len = 0;
         chk_rst = 1;
      end else if (m_valid) begin
         if (chk_rst) begin
            check("rst_inj_serial", 32'(inj_serial), 32'd0);
            check("rst_ej_busy", 32'(ej_busy), 32'd0);
            check("rst_sent", 32'(sent_count), 32'd0);
            check("rst_recv", 32'(recv_count), 32'd0);
            check("rst_err", 32'(err_count), 32'd0);
            check("rst_last_flit", 32'(last_rx_flit), 32'd0);
            chk_rst = 0;
         end
         // Predict: an idle injector takes a flit on the first qualifying cycle.
         if (!m_pending && cyc >= idle_at && enable && (m_lfsr[7:0] < rate)) begin
            inj_q.push_back({2'b01, m_seq, m_lfsr[8+ADDR_SZ-1:8]});
            inj_q_cyc.push_back(cyc);
            m_pending = 1;
         end
         if (chk_sent) begin
            check("sent_count", 32'(sent_count), 32'(m_sent));
            chk_sent = 0;
         end
         // Injection frame decoder
         if (!in_frame) begin
            if (inj_serial) begin
               check("inj_start_expected", 32'(inj_q.size() != 0), 32'd1);
               if (inj_q.size() != 0) begin
                  longint lc;
                  cur_exp = inj_q.pop_front();
                  lc = inj_q_cyc.pop_front();
                  check("inj_start_timing",
                        32'((cyc >= lc + 2) && !busy_prev && (cyc == lc + 2 || busy_prev2)), 32'd1);
               end else begin
                  cur_exp = 'x;
               end
               check("inj_frame_spacing", 32'(cyc - last_start >= FW + 3), 32'd1);
               last_start = cyc;
               in_frame = 1;
               bit_n = 0;
            end
         end else begin
            dec[bit_n] = inj_serial;
            bit_n++;
            if (bit_n == FW) begin
               in_frame = 0;
               check("inj_flit", 32'(dec), 32'(cur_exp));
               m_sent++;
               m_seq++;
               m_pending = 0;
               idle_at = cyc + 2;
               chk_sent = 1;
               if (loop) ej_q.push_back(dec);
            end
         end
         // Ejection monitor
         if (ej_busy) begin
            busy_len++;
         end else if (busy_d) begin
            check("ej_busy_len", 32'(busy_len), 32'(FW));
            check("ej_expected_avail", 32'(ej_q.size() != 0), 32'd1);
            if (ej_q.size() != 0) begin
               logic [FW-1:0] e;
               e = ej_q.pop_front();
               m_recv++;
               if (e[ADDR_SZ-1:0] != ADDR_SZ'(NODE_ID)) m_err++;
               check("ej_last_flit", 32'(last_rx_flit), 32'(e));
               check("ej_recv_count", 32'(recv_count), 32'(m_recv));
               check("ej_err_count", 32'(err_count), 32'(m_err));
            end
            busy_len = 0;
         end
         busy_d = ej_busy;
      end
      busy_prev2 = busy_prev;
      busy_prev  = inj_busy;
      m_lfsr = reset ? SEED : lfsr_step(m_lfsr);
      cyc++;
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      tick();
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic send_ej(input logic [FW-1:0] f, input int gap);
      ej_q.push_back(f);
      tick();
      ej_drv = 1'b1;
      for (int i = 0; i < FW; i++) begin
         tick();
         ej_drv = f[i];
      end
      for (int i = 0; i < gap; i++) begin
         tick();
         ej_drv = 1'b0;
      end
   endtask

   initial begin
      longint rel;
      int     waited;

      // 1: rate 0 never injects
      enable = 1'b1; rate = 8'd0;
      do_reset(3);
      repeat (1000) tick();
      check("rate0_sent", 32'(sent_count), 32'd0);
      check("rate0_no_pending", 32'(inj_q.size()), 32'd0);

      // 2: loopback at full rate, then randomised rate/enable/busy
      loop = 1'b1; rate = 8'd255;
      repeat (400) tick();
      for (int i = 0; i < 1500; i++) begin
         tick();
         inj_busy = ($urandom_range(0, 3) == 0);
         if (i % 100 == 0) rate = 8'($urandom_range(0, 255));
         if (i % 37 == 0) enable = ($urandom_range(0, 4) != 0);
      end
      enable = 1'b0; inj_busy = 1'b0;
      repeat (40) tick();
      check("loop_drain_inj_q", 32'(inj_q.size()), 32'd0);
      check("loop_drain_ej_q", 32'(ej_q.size()), 32'd0);
      check("loop_recv_vs_model", 32'(recv_count), 32'(m_recv));

      // 3: busy holds a pending flit; start bit one cycle after release
      loop = 1'b0; enable = 1'b1; rate = 8'd255; inj_busy = 1'b1;
      do_reset(2);
      repeat (50) tick();
      inj_busy = 1'b0;
      rel = cyc;
      repeat (10) tick();
      check("busy_release_start", 32'(last_start), 32'(rel + 1));
      enable = 1'b0;
      repeat (40) tick();
      check("busy_sent", 32'(sent_count), 32'(m_sent));

      // 4: directed ejection frames, back-to-back, then random frames
      do_reset(2);
      send_ej(14'h1235, 0);
      send_ej(14'h0013, 3);
      check("ej_dir_recv", 32'(recv_count), 32'd2);
      check("ej_dir_err", 32'(err_count), 32'd1);
      check("ej_dir_last", 32'(last_rx_flit), 32'h0013);
      for (int i = 0; i < 20; i++)
         send_ej(FW'($urandom), (i == 19) ? 3 : $urandom_range(0, 3));

      // 5: reset in the middle of a looped-back frame
      loop = 1'b1; enable = 1'b1; rate = 8'd255;
      waited = 0;
      while (!ej_busy && waited < 100) begin
         tick();
         waited++;
      end
      check("wait_ej_busy", 32'(ej_busy), 32'd1);
      repeat (5) tick();
      do_reset(1);
      repeat (100) tick();
      enable = 1'b0;
      repeat (40) tick();
      check("final_inj_q", 32'(inj_q.size()), 32'd0);
      check("final_ej_q", 32'(ej_q.size()), 32'd0);
      check("final_sent", 32'(sent_count), 32'(m_sent));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
